// File: rtl/stream_demux.sv
// Packet-aware 1-to-N stream demultiplexer with a single registered holding slot.
// The destination is latched on a packet's first beat; out-of-range selects drop the packet.
module stream_demux #(
  parameter int DATA_WIDTH    = 8,
  parameter int OUTPUTS       = 4,
  parameter int OUTPUTS_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [OUTPUTS_WIDTH-1:0] in_select,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic [OUTPUTS-1:0]       out_valid,
  input  logic [OUTPUTS-1:0]       out_ready,
  output logic                     err_select
);

  // Handshake: a beat moves on a port only in a cycle where its valid and ready are both 1;
  // valid never depends on ready, and in_ready depends combinationally on out_ready[dest_q].

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUTE = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  localparam logic [OUTPUTS_WIDTH:0] OUT_CNT = (OUTPUTS_WIDTH + 1)'(OUTPUTS);

  state_e                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     last_q, last_d;
  logic [OUTPUTS_WIDTH-1:0] dest_q, dest_d;
  logic                     err_q, err_d;

  logic [OUTPUTS-1:0]       dest_onehot;
  logic                     dest_ready;
  logic                     sel_bad;
  logic                     in_fire;
  logic                     out_fire;
  logic                     load;

  always_comb begin
    dest_onehot = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      dest_onehot[i] = (dest_q == OUTPUTS_WIDTH'(i));
    end
  end

  assign dest_ready = |(dest_onehot & out_ready);
  assign sel_bad    = ({1'b0, in_select} >= OUT_CNT);
  assign in_ready   = (state_q == S_DROP) || ((state_q == S_IDLE) && sel_bad) ||
                      !valid_q || dest_ready;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = valid_q && dest_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q && !out_fire;
    data_d  = data_q;
    last_d  = last_q;
    dest_d  = dest_q;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          if (sel_bad) begin
            err_d   = 1'b1;
            state_d = in_last ? S_IDLE : S_DROP;
          end else begin
            load    = 1'b1;
            dest_d  = in_select;
            state_d = in_last ? S_IDLE : S_ROUTE;
          end
        end
      end
      S_ROUTE: begin
        if (in_fire) begin
          load = 1'b1;
          if (in_last) state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (in_fire && in_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A load on the same edge as an out fire refills the slot with no bubble.
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      dest_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
    end
  end

  assign out_valid  = valid_q ? dest_onehot : '0;
  assign out_data   = data_q;
  assign out_last   = last_q;
  assign err_select = err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux with three channels, so select value 3 is out of range.
module tb_stream_demux;
  localparam int DW = 8;
  localparam int NO = 3;
  localparam int SW = 2;
  localparam int EW = SW + 1 + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic [SW-1:0] in_select;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [NO-1:0] out_valid;
  logic [NO-1:0] out_ready;
  logic          err_select;

  int            checks = 0;
  int            errors = 0;
  int            err_cnt = 0;
  int            err_before;
  logic [EW-1:0] exp_q[$];
  logic [NO-1:0] ready_cfg;
  bit            rand_bp;

  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    logic          last;
    bit            drop;
    logic [SW-1:0] dest;
  } vec_t;
  vec_t vecs[12];

  stream_demux #(.DATA_WIDTH(DW), .OUTPUTS(NO), .OUTPUTS_WIDTH(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_select (in_select),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_select(err_select)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pops one expected {dest, last, data} per delivered beat.
  task automatic monitor_loop();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid_onehot", 32'($countones(out_valid) <= 1), 32'd1);
        for (int d = 0; d < NO; d++) begin
          if (out_valid[d] && out_ready[d]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: ch %0d data 0x%0h, expected no beat", d, out_data);
            end else begin
              e = exp_q.pop_front();
              chk("delivered_beat", 32'({SW'(d), out_last, out_data}), 32'(e));
            end
          end
        end
        if (err_select) err_cnt++;
      end
    end
  endtask

  // Driver: one cycle of input; pushes the expectation if the beat is accepted.
  task automatic step(input logic [SW-1:0] sel, input logic [DW-1:0] data, input logic valid,
                      input logic last, input bit drop, input logic [SW-1:0] dest);
    @(posedge clk);
    #1;
    in_valid  = valid;
    in_select = sel;
    in_data   = data;
    in_last   = last;
    out_ready = rand_bp ? NO'($urandom_range(0, 7)) : ready_cfg;
    @(negedge clk);
    if (valid && in_ready && !drop) exp_q.push_back({dest, last, data});
  endtask

  task automatic idle_step();
    step('0, '0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic send(input vec_t v);
    bit fired;
    fired = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_select = v.sel;
    in_data   = v.data;
    in_last   = v.last;
    out_ready = rand_bp ? NO'($urandom_range(0, 7)) : ready_cfg;
    for (int c = 0; c < 64 && !fired; c++) begin
      @(negedge clk);
      if (in_ready) begin
        fired = 1'b1;
        if (!v.drop) exp_q.push_back({v.dest, v.last, v.data});
      end else begin
        @(posedge clk);
        #1;
        out_ready = rand_bp ? NO'($urandom_range(0, 7)) : ready_cfg;
      end
    end
    if (!fired) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat 0x%0h not accepted, expected acceptance", v.data);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_select = '0;
    out_ready = '0;
    ready_cfg = '1;
    rand_bp   = 1'b0;

    vecs[0]  = '{sel: 2'd1, data: 8'h10, last: 1'b1, drop: 1'b0, dest: 2'd1};
    vecs[1]  = '{sel: 2'd3, data: 8'h20, last: 1'b1, drop: 1'b1, dest: 2'd0};
    vecs[2]  = '{sel: 2'd0, data: 8'h30, last: 1'b0, drop: 1'b0, dest: 2'd0};
    vecs[3]  = '{sel: 2'd2, data: 8'h31, last: 1'b0, drop: 1'b0, dest: 2'd0};
    vecs[4]  = '{sel: 2'd3, data: 8'h32, last: 1'b1, drop: 1'b0, dest: 2'd0};
    vecs[5]  = '{sel: 2'd3, data: 8'h40, last: 1'b0, drop: 1'b1, dest: 2'd0};
    vecs[6]  = '{sel: 2'd1, data: 8'h41, last: 1'b0, drop: 1'b1, dest: 2'd0};
    vecs[7]  = '{sel: 2'd0, data: 8'h42, last: 1'b1, drop: 1'b1, dest: 2'd0};
    vecs[8]  = '{sel: 2'd2, data: 8'h50, last: 1'b0, drop: 1'b0, dest: 2'd2};
    vecs[9]  = '{sel: 2'd1, data: 8'h51, last: 1'b1, drop: 1'b0, dest: 2'd2};
    vecs[10] = '{sel: 2'd2, data: 8'h60, last: 1'b1, drop: 1'b0, dest: 2'd2};
    vecs[11] = '{sel: 2'd0, data: 8'h70, last: 1'b1, drop: 1'b0, dest: 2'd0};

    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset values, then a 3-beat packet to channel 2
    step(2'd2, 8'h11, 1'b1, 1'b0, 1'b0, 2'd2);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(err_select), 32'd0);
    step(2'd0, 8'h22, 1'b1, 1'b0, 1'b0, 2'd2);
    chk("a_valid1", 32'(out_valid), 32'h4);
    chk("a_data1", 32'(out_data), 32'h11);
    chk("a_last1", 32'(out_last), 32'd0);
    step(2'd0, 8'h33, 1'b1, 1'b1, 1'b0, 2'd2);
    chk("a_valid2", 32'(out_valid), 32'h4);
    chk("a_data2", 32'(out_data), 32'h22);
    chk("a_last2", 32'(out_last), 32'd0);
    idle_step();
    chk("a_valid3", 32'(out_valid), 32'h4);
    chk("a_data3", 32'(out_data), 32'h33);
    chk("a_last3", 32'(out_last), 32'd1);
    idle_step();
    chk("a_idle", 32'(out_valid), 32'd0);

    // Select changes mid-packet are ignored
    step(2'd1, 8'h44, 1'b1, 1'b0, 1'b0, 2'd1);
    step(2'd3, 8'h45, 1'b1, 1'b0, 1'b0, 2'd1);
    chk("b_valid1", 32'(out_valid), 32'h2);
    step(2'd3, 8'h46, 1'b1, 1'b1, 1'b0, 2'd1);
    chk("b_valid2", 32'(out_valid), 32'h2);
    idle_step();
    chk("b_valid3", 32'(out_valid), 32'h2);
    chk("b_data3", 32'(out_data), 32'h46);
    idle_step();

    // Backpressure on channel 0 while channel 1 is ready
    ready_cfg = 3'b010;
    step(2'd0, 8'hA1, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("c_ready_first", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(2'd0, 8'hA2, 1'b1, 1'b1, 1'b0, 2'd0);
      chk("c_ready_held", 32'(in_ready), 32'd0);
      chk("c_data_stable", 32'(out_data), 32'hA1);
      chk("c_valid_held", 32'(out_valid), 32'h1);
    end
    ready_cfg = 3'b111;
    step(2'd0, 8'hA2, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("c_ready_release", 32'(in_ready), 32'd1);
    idle_step();
    chk("c_valid_last", 32'(out_valid), 32'h1);
    chk("c_data_last", 32'(out_data), 32'hA2);
    chk("c_last", 32'(out_last), 32'd1);
    idle_step();
    chk("c_idle", 32'(out_valid), 32'd0);

    // Out-of-range select drops a 2-beat packet
    step(2'd3, 8'hB0, 1'b1, 1'b0, 1'b1, 2'd0);
    chk("d_ready0", 32'(in_ready), 32'd1);
    chk("d_err0", 32'(err_select), 32'd0);
    step(2'd0, 8'hB1, 1'b1, 1'b1, 1'b1, 2'd0);
    chk("d_ready1", 32'(in_ready), 32'd1);
    chk("d_err1", 32'(err_select), 32'd1);
    chk("d_valid1", 32'(out_valid), 32'd0);
    step(2'd0, 8'hC0, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("d_ready2", 32'(in_ready), 32'd1);
    chk("d_err2", 32'(err_select), 32'd0);
    chk("d_valid2", 32'(out_valid), 32'd0);
    idle_step();
    chk("d_valid3", 32'(out_valid), 32'h1);
    chk("d_data3", 32'(out_data), 32'hC0);
    chk("d_err3", 32'(err_select), 32'd0);
    idle_step();

    // Back-to-back single-beat packets to 0, 1, 2, 0
    step(2'd0, 8'hD0, 1'b1, 1'b1, 1'b0, 2'd0);
    step(2'd1, 8'hD1, 1'b1, 1'b1, 1'b0, 2'd1);
    chk("e_valid0", 32'(out_valid), 32'h1);
    chk("e_ready1", 32'(in_ready), 32'd1);
    step(2'd2, 8'hD2, 1'b1, 1'b1, 1'b0, 2'd2);
    chk("e_valid1", 32'(out_valid), 32'h2);
    step(2'd0, 8'hD3, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("e_valid2", 32'(out_valid), 32'h4);
    idle_step();
    chk("e_valid3", 32'(out_valid), 32'h1);
    idle_step();
    chk("e_idle", 32'(out_valid), 32'd0);

    // Asynchronous reset with a beat held in the register mid-packet
    ready_cfg = 3'b000;
    step(2'd2, 8'hE0, 1'b1, 1'b0, 1'b1, 2'd2);
    idle_step();
    chk("f_valid_pre", 32'(out_valid), 32'h4);
    chk("f_data_pre", 32'(out_data), 32'hE0);
    #2 rst_n = 1'b0;
    #1;
    chk("f_valid_rst", 32'(out_valid), 32'd0);
    chk("f_data_rst", 32'(out_data), 32'd0);
    chk("f_last_rst", 32'(out_last), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    ready_cfg = 3'b111;
    step(2'd1, 8'hF0, 1'b1, 1'b1, 1'b0, 2'd1);
    chk("f_ready_post", 32'(in_ready), 32'd1);
    idle_step();
    chk("f_valid_post", 32'(out_valid), 32'h2);
    chk("f_data_post", 32'(out_data), 32'hF0);
    idle_step();

    // Table of packets under random backpressure
    err_before = err_cnt;
    rand_bp = 1'b1;
    for (int i = 0; i < 12; i++) send(vecs[i]);
    rand_bp = 1'b0;
    ready_cfg = 3'b111;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle_step();
    idle_step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("table_err_pulses", 32'(err_cnt - err_before), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
